// File: rtl/me_pkg.sv
// Shared types and width helpers for the motion-estimation scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package me_pkg;

  // Core geometry the default widths are derived from.
  localparam int TB_LENGTH    = 16;  // template block edge, pixels
  localparam int SW_LENGTH    = 49;  // search window edge, candidate positions
  localparam int PE_OUT_WIDTH = 8;   // per-pixel absolute difference width

  // SAD accumulates TB_LENGTH^2 absolute differences.
  function automatic int sad_width(input int tb_length, input int pe_out_width);
    return $clog2(tb_length * tb_length) + pe_out_width;
  endfunction

  // Motion-vector index enumerates SW_LENGTH^2 candidate positions.
  function automatic int cnt_width(input int sw_length);
    return $clog2(sw_length * sw_length);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    RESP,
    RESP_TO,
    DRAIN
  } state_t;

  // Error SAD is all-ones; sliced down to the instance SAD width.
  localparam logic [63:0] SAD_ERR = '1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, contention goes to the
// requester that did not win last time. Latency: gnt is combinational from req.
// Backpressure: last_grant only moves when advance is high and a grant is made.
// Ports: clk, rst_n; req[1:0] requests; advance = caller is taking the grant;
//        gnt[1:0] one-hot grant (zero when no request).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 after reset so requester 0 wins the first contention.
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/me_scheduler.sv
// Shares one ME core between two requesters; returns latched SAD/vector or a timeout error.
// Latency: grant -> core_req next cycle; core_ack -> res_valid next cycle; min period BUSY+2.
// Backpressure: result held until res_ready[owner]; no new grant until the result is taken.
// Ports: req_valid/req_blk/req_ready job request per requester (req_ready one-hot, comb.);
//        core_req/core_blk/core_ack/core_sad/core_mvec core handshake;
//        res_valid/res_ready/res_sad/res_mvec/res_err result channel to the owner.
module me_scheduler
  import me_pkg::*;
#(
  parameter int SAD_WIDTH = sad_width(TB_LENGTH, PE_OUT_WIDTH),
  parameter int CNT_WIDTH = cnt_width(SW_LENGTH),
  parameter int BLK_WIDTH = 8,
  parameter int TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [2*BLK_WIDTH-1:0] req_blk,
  output logic [1:0]             req_ready,
  output logic                   core_req,
  output logic [BLK_WIDTH-1:0]   core_blk,
  input  logic                   core_ack,
  input  logic [SAD_WIDTH-1:0]   core_sad,
  input  logic [CNT_WIDTH-1:0]   core_mvec,
  output logic [1:0]             res_valid,
  input  logic [1:0]             res_ready,
  output logic [SAD_WIDTH-1:0]   res_sad,
  output logic [CNT_WIDTH-1:0]   res_mvec,
  output logic                   res_err
);

  localparam int WD_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT - 1);

  state_t              state;
  logic                owner;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic [1:0]          gnt;
  logic                is_idle;

  assign is_idle = (state == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (is_idle),
    .gnt     (gnt)
  );

  // Gated by rst_n so the accept pulse also drops while reset is held.
  assign req_ready = (is_idle && rst_n) ? gnt : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      wd_cnt    <= '0;
      core_req  <= 1'b0;
      core_blk  <= '0;
      res_valid <= 2'b00;
      res_sad   <= '0;
      res_mvec  <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            owner    <= gnt[1];
            core_blk <= gnt[1] ? req_blk[2*BLK_WIDTH-1 -: BLK_WIDTH]
                               : req_blk[BLK_WIDTH-1:0];
            wd_cnt   <= '0;
            core_req <= 1'b1;
            state    <= BUSY;
          end
        end

        BUSY: begin
          // Ack is checked first so an ack on the limit cycle still counts.
          if (core_ack) begin
            res_sad   <= core_sad;
            res_mvec  <= core_mvec;
            res_err   <= 1'b0;
            core_req  <= 1'b0;
            res_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end else if (wd_cnt == WD_LIMIT) begin
            res_sad   <= SAD_ERR[SAD_WIDTH-1:0];
            res_mvec  <= '0;
            res_err   <= 1'b1;
            core_req  <= 1'b0;
            res_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP_TO;
          end else begin
            wd_cnt <= wd_cnt + WD_WIDTH'(1);
          end
        end

        RESP, RESP_TO: begin
          if (res_ready[owner]) begin
            res_valid <= 2'b00;
            // After a timeout the core still owes an ack; swallow it before regranting.
            state     <= (state == RESP) ? IDLE : DRAIN;
          end
        end

        DRAIN: begin
          if (core_ack) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_scheduler.sv
// Randomized scoreboard bench for me_scheduler with a behavioural core and arbitration model.
module tb_me_scheduler;

  localparam int SW = 16;
  localparam int CW = 12;
  localparam int BW = 8;
  localparam int TO = 48;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [2*BW-1:0] req_blk;
  logic [1:0]      req_ready;
  logic            core_req;
  logic [BW-1:0]   core_blk;
  logic            core_ack;
  logic [SW-1:0]   core_sad;
  logic [CW-1:0]   core_mvec;
  logic [1:0]      res_valid;
  logic [1:0]      res_ready;
  logic [SW-1:0]   res_sad;
  logic [CW-1:0]   res_mvec;
  logic            res_err;

  me_scheduler #(
    .SAD_WIDTH (SW),
    .CNT_WIDTH (CW),
    .BLK_WIDTH (BW),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_blk   (req_blk),
    .req_ready (req_ready),
    .core_req  (core_req),
    .core_blk  (core_blk),
    .core_ack  (core_ack),
    .core_sad  (core_sad),
    .core_mvec (core_mvec),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sad   (res_sad),
    .res_mvec  (res_mvec),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        owner;
    bit [7:0]  blk;
    int        k;     // core answers on watchdog cycle k; k >= TO means it answers late
    bit [15:0] sad;
    bit [11:0] mvec;
  } job_t;

  job_t b0[$], b1[$];                 // batch being composed
  job_t rq0[$], rq1[$];               // jobs still to be offered by each requester
  job_t core_q[$], gnt_q[$], res_q[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;
  bit  model_last = 1'b1;
  bit  manual = 1'b0;
  bit  long_hold = 1'b0;
  bit  draining = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input bit o);
    return o ? 2'b10 : 2'b01;
  endfunction

  function automatic job_t mk(input bit [7:0] blk, input int k, input bit [15:0] sad,
                              input bit [11:0] mvec);
    job_t j;
    j.owner = 1'b0; j.blk = blk; j.k = k; j.sad = sad; j.mvec = mvec;
    return j;
  endfunction

  function automatic job_t mk_rand();
    int r;
    int k;
    r = $urandom_range(0, 9);
    if (r < 7)       k = $urandom_range(0, 12);
    else if (r == 7) k = TO - 1;
    else if (r == 8) k = TO + $urandom_range(0, 3);
    else             k = $urandom_range(13, TO - 2);
    return mk(8'($urandom), k, 16'($urandom), 12'($urandom));
  endfunction

  // Reference arbitration: lone pending requester wins, otherwise alternate.
  task automatic plan_batch();
    int i0 = 0;
    int i1 = 0;
    bit g;
    job_t j;
    while (i0 < b0.size() || i1 < b1.size()) begin
      if (i0 < b0.size() && i1 < b1.size()) g = !model_last;
      else g = (i0 < b0.size()) ? 1'b0 : 1'b1;
      model_last = g;
      if (!g) begin j = b0[i0]; i0++; end
      else    begin j = b1[i1]; i1++; end
      j.owner = g;
      core_q.push_back(j);
      gnt_q.push_back(j);
      res_q.push_back(j);
    end
    foreach (b0[i]) rq0.push_back(b0[i]);
    foreach (b1[i]) rq1.push_back(b1[i]);
  endtask

  task automatic run_batch();
    int target;
    int cyc;
    @(negedge clk); #1;
    target = done_cnt + b0.size() + b1.size();
    plan_batch();
    cyc = 0;
    while (done_cnt < target && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check("batch_done", done_cnt, target);
    b0.delete();
    b1.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_core_req"},  core_req,  0);
    check({tag, "_core_blk"},  core_blk,  0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_sad"},   res_sad,   0);
    check({tag, "_res_mvec"},  res_mvec,  0);
    check({tag, "_res_err"},   res_err,   0);
  endtask

  // Requesters and result consumers.
  initial begin : drive
    logic [1:0] acc;
    logic [1:0] vprev;
    int hold [2];
    vprev = 2'b00;
    hold[0] = 0; hold[1] = 0;
    req_valid = 2'b00; req_blk = '0; res_ready = 2'b00;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (acc[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (acc[1] && rq1.size() > 0) void'(rq1.pop_front());
      req_valid = {rq1.size() > 0, rq0.size() > 0};
      req_blk[BW-1:0]    = (rq0.size() > 0) ? rq0[0].blk : 8'($urandom);
      req_blk[2*BW-1:BW] = (rq1.size() > 0) ? rq1[0].blk : 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (res_valid[i] && !vprev[i]) hold[i] = long_hold ? 10 : $urandom_range(0, 3);
        if (res_valid[i]) begin
          res_ready[i] = (hold[i] == 0);
          if (hold[i] > 0) hold[i]--;
        end else begin
          res_ready[i] = 1'($urandom_range(0, 1));
        end
        vprev[i] = res_valid[i];
      end
    end
  end

  // Behavioural ME core.
  initial begin : core
    job_t j;
    int n;
    core_ack = 1'b0; core_sad = '0; core_mvec = '0;
    forever begin
      @(posedge clk); #1;
      core_ack = 1'b0; core_sad = 16'($urandom); core_mvec = 12'($urandom);
      if (manual || !rst_n) continue;
      if (!core_req) begin
        // Stray acks while the core is not owed one must be ignored.
        if (!draining && $urandom_range(0, 7) == 0) core_ack = 1'b1;
        continue;
      end
      if (core_q.size() == 0) begin
        check("core_req_unexpected", core_req, 0);
        continue;
      end
      j = core_q.pop_front();
      if (j.k >= TO) draining = 1'b1;
      n = (j.k < TO) ? j.k : TO;
      for (int c = 0; c < n; c++) begin
        check("core_busy", {core_req, core_blk}, {1'b1, j.blk});
        @(posedge clk); #1;
      end
      if (j.k < TO) begin
        check("core_busy_ack", {core_req, core_blk}, {1'b1, j.blk});
        core_ack = 1'b1; core_sad = j.sad; core_mvec = j.mvec;
        @(posedge clk); #1;
        core_ack = 1'b0; core_sad = 16'($urandom); core_mvec = 12'($urandom);
        check("ack_to_resp", {core_req, res_valid}, {1'b0, onehot(j.owner)});
      end else begin
        check("timeout_resp", {core_req, res_valid}, {1'b0, onehot(j.owner)});
        n = 0;
        while (res_valid != 2'b00 && n < 500) begin
          @(posedge clk); #1;
          n++;
        end
        check("drain_entered", n < 500, 1);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        core_ack = 1'b1;
        @(posedge clk); #1;
        core_ack = 1'b0;
        draining = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin : mon
    job_t e;
    job_t cur;
    bit held;
    bit exp_core;
    bit after_acc;
    bit err;
    int outstanding;
    logic [7:0] eblk;
    held = 0; exp_core = 0; after_acc = 0; outstanding = 0; eblk = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0; exp_core = 0; after_acc = 0; outstanding = 0;
        continue;
      end
      if (exp_core) begin
        check("core_start", {core_req, core_blk}, {1'b1, eblk});
        exp_core = 0;
      end
      if (after_acc) begin
        check("res_valid_drop", res_valid, 0);
        after_acc = 0;
      end
      if (req_ready != 2'b00) begin
        check("grant_gap", (outstanding == 0 && !draining), 1);
        if (gnt_q.size() == 0) begin
          check("grant_unexpected", req_ready, 0);
        end else begin
          e = gnt_q.pop_front();
          check("grant_owner", req_ready, onehot(e.owner));
          eblk = e.blk;
          exp_core = 1;
          outstanding++;
        end
      end
      if (res_valid != 2'b00) begin
        if (!held) begin
          if (res_q.size() == 0) check("result_unexpected", res_valid, 0);
          else begin
            cur = res_q.pop_front();
            held = 1;
          end
        end
        if (held) begin
          err = (cur.k >= TO);
          check("res_valid", res_valid, onehot(cur.owner));
          check("res_err", res_err, err);
          check("res_sad", res_sad, err ? 16'hFFFF : cur.sad);
          check("res_mvec", res_mvec, err ? 12'h000 : cur.mvec);
          if (res_valid[cur.owner] && res_ready[cur.owner]) begin
            held = 0;
            outstanding--;
            done_cnt++;
            after_acc = 1;
          end
        end
      end else if (held) begin
        check("res_valid_held", res_valid, onehot(cur.owner));
        held = 0;
      end
    end
  end

  initial begin : guard
    #800000;
    $display("FAIL global_timeout: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin : main
    int cyc;
    job_t j;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #7;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Contention from reset: grants alternate starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      j = mk_rand(); j.k = $urandom_range(0, 12); b0.push_back(j);
      j = mk_rand(); j.k = $urandom_range(0, 12); b1.push_back(j);
    end
    run_batch();

    // Requester 0 times out, requester 1 waits through the drain then acks on the limit cycle.
    b0.push_back(mk(8'h33, TO, 16'h1111, 12'h111));
    b1.push_back(mk(8'h44, TO - 1, 16'h2222, 12'h222));
    run_batch();

    // Single job with a long result backpressure window.
    long_hold = 1'b1;
    b0.push_back(mk(8'h05, 40, 16'h0123, 12'h4A0));
    run_batch();
    long_hold = 1'b0;

    // Random batches.
    for (int r = 0; r < 25; r++) begin
      int n0;
      int n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) b0.push_back(mk_rand());
      for (int i = 0; i < n1; i++) b1.push_back(mk_rand());
      long_hold = ($urandom_range(0, 3) == 0);
      run_batch();
    end
    long_hold = 1'b0;

    // Reset in the middle of a job.
    cyc = 0;
    while (draining && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    check("pre_reset_idle", draining, 0);
    @(negedge clk); #1;
    manual = 1'b1;
    j = mk(8'h77, 0, 16'h0, 12'h0);
    gnt_q.push_back(j);
    rq0.push_back(j);
    cyc = 0;
    while (!core_req && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reset_job_started", core_req, 1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    rq0.delete(); rq1.delete(); gnt_q.delete(); core_q.delete(); res_q.delete();
    model_last = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    manual = 1'b0;
    for (int i = 0; i < 2; i++) begin
      j = mk_rand(); j.k = $urandom_range(0, 12); b0.push_back(j);
      j = mk_rand(); j.k = $urandom_range(0, 12); b1.push_back(j);
    end
    run_batch();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/me_scheduler.md
# me_scheduler

Shares one motion-estimation core between two requesters, e.g. two encoder channels. Each job names a template block. The scheduler arbitrates round-robin between the requesters and drives the core's req/ack handshake and block select. It latches the core's min_sad/min_mvec and returns them to the winning requester over a valid/ready result channel. A watchdog turns a hung core into an error response and then drains the stray ack.

## Interface
- SAD_WIDTH, 16, core SAD width ($clog2(16**2)+8)
- CNT_WIDTH, 12, core motion-vector index width ($clog2(49**2))
- BLK_WIDTH, 8, block-id width
- TIMEOUT, 65535, max BUSY cycles before error; must be ≥2
- Reset: one clock; reset is asynchronous and active-low (rst_n, clk).
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  2  job request per requester
- req_blk  in  2*BLK_WIDTH  block id; requester i uses bits [i*BLK_WIDTH +: BLK_WIDTH]
- req_ready  out  2  one-hot accept pulse
- core_req  out  1  request to the ME core
- core_blk  out  BLK_WIDTH  block id to the core, stable while core_req=1
- core_ack  in  1  one-cycle done pulse from the core
- core_sad  in  SAD_WIDTH  core min_sad, valid when core_ack=1
- core_mvec  in  CNT_WIDTH  core min_mvec, valid when core_ack=1
- res_valid  out  2  one-hot result valid
- res_ready  in  2  result accept per requester
- res_sad  out  SAD_WIDTH  latched SAD
- res_mvec  out  CNT_WIDTH  latched vector index
- res_err  out  1  1 = timed out

## Operation
- States:
  - IDLE: if any req_valid, grant one. Assert req_ready[g] combinationally, latch the requester's req_blk into core_blk and g into owner. Go to BUSY.
  - BUSY: core_req=1 and the watchdog counts.
    - core_ack=1 → latch core_sad/core_mvec, res_err=0 → RESP.
    - Count reaches TIMEOUT-1 with no ack → res_sad=all-ones, res_mvec=0, res_err=1 → RESP_TO.
  - RESP / RESP_TO: res_valid[owner]=1 until res_ready[owner]=1.
    - RESP → IDLE.
    - RESP_TO → DRAIN.
  - DRAIN: core_req=0. Wait for core_ack; the ack and its data are discarded → IDLE. No grants while draining.
- Arbitration:
  - Round-robin via last_grant.
  - Both valid → grant !last_grant.
  - Single valid → grant it regardless of last_grant.
  - last_grant updates on each grant.
- req_ready and res_valid are never asserted to a requester other than owner. res_ready to a non-owner is ignored.
- Requesters hold req_valid/req_blk until req_ready; a deasserted req_valid is simply not granted.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first contention), owner=0.
  - All outputs 0, including core_blk and res_err; res_sad=0.
- Accept in cycle T → core_req=1 from T+1. core_blk is valid from T+1 and held until the next grant.
- core_ack at cycle N → core_req=0 and res_valid=1 at N+1. Results are stable while res_valid=1.
- res_ready in cycle M → res_valid=0 at M+1. The next grant can occur at M+1.
- Minimum job period = BUSY length + 2 cycles.
- Watchdog:
  - Cleared on BUSY entry; counts 0..TIMEOUT-1.
  - core_ack in the same cycle as the limit: the ack wins, normal result.
- core_ack outside BUSY/DRAIN is ignored.
- rst_n low mid-job: everything returns to reset values immediately, core_req drops, no result is issued. The core is reset by the same rst_n.

## Structure
- Shared package me_pkg:
  - SAD_WIDTH/CNT_WIDTH derivation functions from TB_LENGTH/SW_LENGTH/PE_OUT_WIDTH.
  - State enum {IDLE, BUSY, RESP, RESP_TO, DRAIN}.
  - Constant SAD_ERR = all-ones.
- One sub-module, rr_arb2: 2-way round-robin with inputs req[1:0], advance, last_grant register, output one-hot gnt.
- Watchdog counter and result registers stay in the top.

## Test plan
- Single job: req_valid=01, blk=0x05. Core acks after 40 cycles with sad=0x0123, mvec=0x4A0. Expect:
  - core_blk=0x05 while core_req=1.
  - res_valid=01 with sad=0x0123, mvec=0x4A0, err=0.
- Contention: req_valid=11 from reset, 4 jobs each side. Grants alternate 0,1,0,1…; each result goes to the correct owner only.
- Backpressure: hold res_ready=0 for 10 cycles. Expect:
  - res_valid, res_sad and res_mvec stay stable.
  - No new grant until one cycle after res_ready.
- Timeout: TIMEOUT=8, no ack. Expect:
  - res_err=1, sad=0xFFFF, mvec=0.
  - After res_ready, a late ack is discarded in DRAIN; requester 1, pending throughout, is granted only after that ack.
- Edge: ack on watchdog cycle 7 with TIMEOUT=8 gives a normal result, err=0.
- Reset mid-BUSY: drop rst_n with core_req=1. Expect:
  - All outputs 0 asynchronously.
  - After release, requester 0 wins contention.
